// File: rtl/md_pkg.sv
// HI/LO multiply/divide issue control: shared encodings and types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_pkg;

    // Opcode and funct codes of the HI/LO instruction group
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] F_MULT      = 6'h18;
    localparam logic [5:0] F_MULTU     = 6'h19;
    localparam logic [5:0] F_DIV       = 6'h1A;
    localparam logic [5:0] F_DIVU      = 6'h1B;
    localparam logic [5:0] F_MFHI      = 6'h10;
    localparam logic [5:0] F_MTHI      = 6'h11;
    localparam logic [5:0] F_MFLO      = 6'h12;
    localparam logic [5:0] F_MTLO      = 6'h13;

    // md_op encodings (match funct[1:0] of the calc group)
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // md_we encodings
    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_HI   = 2'b01;
    localparam logic [1:0] WE_LO   = 2'b10;

    // rd_sel encodings
    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_HI   = 2'b01;
    localparam logic [1:0] RD_LO   = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_CALC
    } md_state_t;

    // What was issued into EX/MEM last cycle
    typedef enum logic [1:0] {
        MK_NONE,
        MK_CALC,
        MK_MOVE
    } mem_kind_t;

    typedef enum logic [1:0] {
        CLS_OTHER,
        CLS_CALC,
        CLS_MTO,
        CLS_MFROM
    } md_class_t;

    // Divides have op[1] set; multiplies do not
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_decode.sv
// Decodes an EX instruction into HI/LO class, md_op and HI/LO select.
// Latency: purely combinational.
// Backpressure: none.
// Ports: instr (in, 32) -> cls (class), op (md_op for calc class), sel_hi (1 = HI, 0 = LO for moves).
module md_decode
    import md_pkg::*;
(
    input  logic [31:0] instr,
    output md_class_t   cls,
    output logic [1:0]  op,
    output logic        sel_hi
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    always_comb begin
        cls    = CLS_OTHER;
        op     = OP_MULT;
        sel_hi = 1'b0;
        if (opcode == OPC_SPECIAL) begin
            case (funct)
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    cls = CLS_CALC;
                    op  = funct[1:0];
                end
                F_MFHI: begin
                    cls    = CLS_MFROM;
                    sel_hi = 1'b1;
                end
                F_MFLO: cls = CLS_MFROM;
                F_MTHI: begin
                    cls    = CLS_MTO;
                    sel_hi = 1'b1;
                end
                F_MTLO: cls = CLS_MTO;
                default: cls = CLS_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for the HI/LO multiply/divide unit; tracks busy window, stalls, cancel/restore on interrupt.
// Latency: all outputs combinational from current state and inputs; busy window is MUL_CYCLES/DIV_CYCLES after issue.
// Backpressure: raises stall for a HI/LO instruction in EX while a calculation is in flight or md_busy is high.
// Ports: clk/reset; instr_ex, valid_ex, int_req, md_busy in; md_start, md_op, md_we, md_restore, md_cancel, rd_sel, stall out.
// MUL_CYCLES and DIV_CYCLES must each lie in 1..15 (4-bit countdown).
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_ex,
    input  logic        valid_ex,
    input  logic        int_req,
    input  logic        md_busy,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic [1:0]  md_we,
    output logic        md_restore,
    output logic        md_cancel,
    output logic [1:0]  rd_sel,
    output logic        stall
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    md_class_t cls;
    logic [1:0] dec_op;
    logic       sel_hi;
    logic       hilo_ex;
    logic       issue;

    md_state_t  state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    mem_kind_t  mem_kind, mem_kind_nxt;

    md_decode u_decode (
        .instr  (instr_ex),
        .cls    (cls),
        .op     (dec_op),
        .sel_hi (sel_hi)
    );

    assign hilo_ex = valid_ex & (cls != CLS_OTHER);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            mem_kind <= MK_NONE;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mem_kind <= mem_kind_nxt;
        end
    end

    // Next-state logic; a cancel overrides the countdown
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (md_cancel) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        state_nxt = ST_CALC;
                        cnt_nxt   = op_is_div(md_op) ? DIV_CNT : MUL_CNT;
                    end
                end
                ST_CALC: begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Outputs. md_busy is ORed into the stall so any skew between the
    // unit's own BUSY and this countdown (e.g. after a reset) still holds EX.
    always_comb begin
        stall        = hilo_ex & ((state == ST_CALC) | md_busy) & ~int_req;
        issue        = hilo_ex & ~stall & ~int_req;
        md_start     = issue & (cls == CLS_CALC);
        md_op        = (hilo_ex && cls == CLS_CALC) ? dec_op : OP_MULT;
        md_we        = WE_NONE;
        rd_sel       = RD_NONE;
        mem_kind_nxt = MK_NONE;
        if (issue) begin
            case (cls)
                CLS_CALC:  mem_kind_nxt = MK_CALC;
                CLS_MTO: begin
                    md_we        = sel_hi ? WE_HI : WE_LO;
                    mem_kind_nxt = MK_MOVE;
                end
                CLS_MFROM: rd_sel = sel_hi ? RD_HI : RD_LO;
                default:   mem_kind_nxt = MK_NONE;
            endcase
        end
        md_cancel  = int_req & (mem_kind == MK_CALC);
        md_restore = int_req & (mem_kind == MK_MOVE);
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios plus randomized traffic against a cycle-count model.
// Latency: n/a.
// Backpressure: n/a.
module tb_md_issue_ctrl;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_ex;
    logic        valid_ex;
    logic        int_req;
    logic        md_busy;
    logic        md_start;
    logic [1:0]  md_op;
    logic [1:0]  md_we;
    logic        md_restore;
    logic        md_cancel;
    logic [1:0]  rd_sel;
    logic        stall;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: remaining busy cycles, and what sits in EX/MEM (0 none, 1 calc, 2 move)
    int m_rem  = 0;
    int m_kind = 0;

    logic [9:0] obs;
    assign obs = {md_start, md_op, md_we, md_restore, md_cancel, rd_sel, stall};

    md_issue_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_ex   (instr_ex),
        .valid_ex   (valid_ex),
        .int_req    (int_req),
        .md_busy    (md_busy),
        .md_start   (md_start),
        .md_op      (md_op),
        .md_we      (md_we),
        .md_restore (md_restore),
        .md_cancel  (md_cancel),
        .rd_sel     (rd_sel),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input logic s, input logic [1:0] op, input logic [1:0] we,
                                      input logic r, input logic c, input logic [1:0] rd, input logic st);
        return {s, op, we, r, c, rd, st};
    endfunction

    function automatic logic [31:0] rt(input logic [5:0] f);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'b000000, mid, f};
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        logic [5:0] opc;
        k = $urandom_range(0, 9);
        case (k)
            0: return rt(6'h18);
            1: return rt(6'h19);
            2: return rt(6'h1A);
            3: return rt(6'h1B);
            4: return rt(6'h10);
            5: return rt(6'h11);
            6: return rt(6'h12);
            7: return rt(6'h13);
            8: begin
                opc = 6'($urandom_range(1, 63));
                return {opc, 20'($urandom), 6'h18 + 6'($urandom_range(0, 3))};
            end
            default: return rt(6'h20 + 6'($urandom_range(0, 15)));
        endcase
    endfunction

    // Expected outputs from the instruction-set rules and the model's busy count
    function automatic logic [9:0] model_eval();
        logic [5:0] f;
        logic special, is_calc, is_mfhi, is_mflo, is_mthi, is_mtlo, hilo, stl, iss, canc, rest;
        logic [1:0] op, we, rd;
        f       = instr_ex[5:0];
        special = (instr_ex[31:26] == 6'd0);
        is_calc = special && (f >= 6'h18 && f <= 6'h1B);
        is_mfhi = special && f == 6'h10;
        is_mthi = special && f == 6'h11;
        is_mflo = special && f == 6'h12;
        is_mtlo = special && f == 6'h13;
        hilo    = valid_ex && (is_calc || is_mfhi || is_mthi || is_mflo || is_mtlo);
        stl     = hilo && (m_rem > 0 || md_busy) && !int_req;
        iss     = hilo && !stl && !int_req;
        op      = (hilo && is_calc) ? f[1:0] : 2'b00;
        we      = (iss && is_mthi) ? 2'b01 : (iss && is_mtlo) ? 2'b10 : 2'b00;
        rd      = (iss && is_mfhi) ? 2'b01 : (iss && is_mflo) ? 2'b10 : 2'b00;
        canc    = int_req && m_kind == 1;
        rest    = int_req && m_kind == 2;
        return mk(iss && is_calc, op, we, rest, canc, rd, stl);
    endfunction

    task automatic next_cycle();
        logic [9:0] e;
        logic       is_mul;
        e      = model_eval();
        is_mul = (instr_ex[5:0] == 6'h18 || instr_ex[5:0] == 6'h19);
        if (e[3])      m_rem = 0;
        else if (e[9]) m_rem = is_mul ? MUL_N : DIV_N;
        else if (m_rem > 0) m_rem = m_rem - 1;
        m_kind = e[9] ? 1 : (e[6:5] != 2'b00) ? 2 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] i, input logic v, input logic ir, input logic b);
        instr_ex = i;
        valid_ex = v;
        int_req  = ir;
        md_busy  = b;
    endtask

    task automatic do_reset();
        set_in(32'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_rem  = 0;
        m_kind = 0;
    endtask

    task automatic test_reset();
        set_in(rt(6'h1B), 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        n_checks++;
        if (obs !== 10'd0) $display("FAIL reset_outputs got %b want %b", obs, 10'd0); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_rem = 0;
        m_kind = 0;
        set_in(rt(6'h11), 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs !== 10'd0) $display("FAIL post_reset_bubble got %b want %b", obs, 10'd0); else n_pass++;
        next_cycle();
    endtask

    task automatic test_mult_mfhi();
        do_reset();
        set_in(rt(6'h18), 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== mk(1, 2'b00, 2'b00, 0, 0, 2'b00, 0)) $display("FAIL mult_issue got %b", obs); else n_pass++;
        next_cycle();
        for (int c = 1; c <= 5; c++) begin
            set_in(rt(6'h10), 1'b1, 1'b0, 1'b0);
            #1;
            n_checks++;
            if (obs !== mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 1)) $display("FAIL mfhi_stall_c%0d got %b want stall", c, obs); else n_pass++;
            next_cycle();
        end
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b00, 0, 0, 2'b01, 0)) $display("FAIL mfhi_release got %b want rd_sel=01", obs); else n_pass++;
        next_cycle();
    endtask

    task automatic test_divu_mtlo();
        int stalls;
        do_reset();
        set_in(rt(6'h1B), 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== mk(1, 2'b11, 2'b00, 0, 0, 2'b00, 0)) $display("FAIL divu_issue got %b", obs); else n_pass++;
        next_cycle();
        stalls = 0;
        for (int c = 1; c <= 10; c++) begin
            set_in(rt(6'h13), 1'b1, 1'b0, 1'b0);
            #1;
            if (stall === 1'b1) stalls++;
            next_cycle();
        end
        n_checks++;
        if (stalls !== 10) $display("FAIL divu_stall_count got %0d want 10", stalls); else n_pass++;
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b10, 0, 0, 2'b00, 0)) $display("FAIL mtlo_release got %b want we=10", obs); else n_pass++;
        next_cycle();
    endtask

    task automatic test_mthi_int();
        do_reset();
        set_in(rt(6'h11), 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b01, 0, 0, 2'b00, 0)) $display("FAIL mthi_issue got %b", obs); else n_pass++;
        next_cycle();
        set_in(rt(6'h10), 1'b1, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b00, 1, 0, 2'b00, 0)) $display("FAIL mthi_restore got %b want restore only", obs); else n_pass++;
        next_cycle();
        set_in(32'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs !== 10'd0) $display("FAIL restore_one_cycle got %b want 0", obs); else n_pass++;
        next_cycle();
    endtask

    task automatic test_div_int();
        do_reset();
        set_in(rt(6'h1A), 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== mk(1, 2'b10, 2'b00, 0, 0, 2'b00, 0)) $display("FAIL div_issue got %b", obs); else n_pass++;
        next_cycle();
        set_in(rt(6'h12), 1'b1, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b00, 0, 1, 2'b00, 0)) $display("FAIL div_cancel got %b want cancel only", obs); else n_pass++;
        next_cycle();
        set_in(rt(6'h12), 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b00, 0, 0, 2'b10, 0)) $display("FAIL mflo_after_cancel got %b want rd_sel=10", obs); else n_pass++;
        next_cycle();
    endtask

    task automatic test_late_int();
        do_reset();
        set_in(rt(6'h18), 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_in(32'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_in(rt(6'h10), 1'b1, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs !== 10'd0) $display("FAIL late_int_no_cancel got %b want 0", obs); else n_pass++;
        next_cycle();
        set_in(rt(6'h10), 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 1)) $display("FAIL late_int_calc_continues got %b want stall", obs); else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid_calc();
        do_reset();
        set_in(rt(6'h18), 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_in(32'd0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 10'd0) $display("FAIL reset_mid_outputs got %b want 0", obs); else n_pass++;
        set_in(rt(6'h10), 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 1)) $display("FAIL reset_mid_busy_stall got %b want stall", obs); else n_pass++;
        md_busy = 1'b0;
        reset   = 1'b0;
        m_rem   = 0;
        m_kind  = 0;
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b00, 0, 0, 2'b01, 0)) $display("FAIL reset_mid_idle got %b want rd_sel=01", obs); else n_pass++;
        set_in(32'd0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_in(32'd0, 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs !== 10'd0) $display("FAIL reset_mid_memkind got %b want 0", obs); else n_pass++;
        next_cycle();
    endtask

    task automatic test_bubble();
        do_reset();
        set_in(rt(6'h18), 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_in(rt(6'h1B), 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== 10'd0) $display("FAIL bubble_in_calc got %b want 0", obs); else n_pass++;
        next_cycle();
        set_in(rt(6'h18), 1'b0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs !== 10'd0) $display("FAIL bubble_memkind got %b want no cancel", obs); else n_pass++;
        next_cycle();
        set_in(rt(6'h12), 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs !== mk(0, 2'b00, 2'b00, 0, 0, 2'b00, 1)) $display("FAIL bubble_calc_continues got %b want stall", obs); else n_pass++;
        next_cycle();
    endtask

    task automatic test_random();
        logic [9:0] e;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_in(rand_instr(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 11) == 0),
                   ($urandom_range(0, 9) == 0));
            #2;
            e = model_eval();
            n_checks++;
            if (obs !== e) $display("FAIL random_c%0d instr=%h got %b want %b", c, instr_ex, obs, e); else n_pass++;
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b0;
        set_in(32'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_mult_mfhi();
        test_divu_mtlo();
        test_mthi_int();
        test_div_int();
        test_late_int();
        test_reset_mid_calc();
        test_bubble();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
